// File: rtl/note_sequencer.sv
// note_sequencer: steps through a note ROM and plays each entry as a square wave.
// Ports:
//   CLOCK_50          - sole clock, rising edge
//   resetn            - asynchronous active-low reset
//   start/stop        - begin playback from IDLE or DONE / abort back to IDLE (stop wins)
//   loop_en           - wrap to address 0 after LAST_ADDR instead of finishing
//   rom_addr, rom_q   - note ROM address out, half-period data in (one-cycle latency)
//   audio_out_allowed - output FIFO has space
//   write_audio_out   - sample write strobe
//   left/right_sample - signed square-wave samples (identical)
//   busy, done        - status: playing (FETCH/LOAD/PLAY) / finished
module note_sequencer #(
    parameter int ADDR_W       = 10,
    parameter int PERIOD_W     = 20,
    parameter int LAST_ADDR    = 252,
    parameter int TEMPO_SWITCH = 197,
    parameter int TEMPO_SLOW   = 9200000,
    parameter int TEMPO_FAST   = 7800000,
    parameter int AMPLITUDE    = 1000000000
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 loop_en,
    output logic [ADDR_W-1:0]    rom_addr,
    input  logic [PERIOD_W-1:0]  rom_q,
    input  logic                 audio_out_allowed,
    output logic                 write_audio_out,
    output logic signed [31:0]   left_sample,
    output logic signed [31:0]   right_sample,
    output logic                 busy,
    output logic                 done
);
    typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, DONE} state_t;
    localparam logic [26:0]        SLOW   = 27'(TEMPO_SLOW);
    localparam logic [26:0]        FAST   = 27'(TEMPO_FAST);
    localparam logic [ADDR_W-1:0]  LAST   = ADDR_W'(LAST_ADDR);
    localparam logic [ADDR_W-1:0]  SWITCH = ADDR_W'(TEMPO_SWITCH);
    localparam logic signed [31:0] AMP    = 32'(AMPLITUDE);
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [26:0]         len_q, len_d, note_cnt_q, note_cnt_d;
    logic [PERIOD_W-1:0] half_cnt_q, half_cnt_d, period_q, period_d;
    logic                phase_q, phase_d, note_end;
    logic signed [31:0]  sample;
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            len_q      <= SLOW;
            note_cnt_q <= '0;
            half_cnt_q <= '0;
            period_q   <= '0;
            phase_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            len_q      <= len_d;
            note_cnt_q <= note_cnt_d;
            half_cnt_q <= half_cnt_d;
            period_q   <= period_d;
            phase_q    <= phase_d;
        end
    end
    assign note_end = (state_q == PLAY) && (note_cnt_q == len_q - 27'd1);
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        len_d      = len_q;
        note_cnt_d = note_cnt_q;
        half_cnt_d = half_cnt_q;
        period_d   = period_q;
        phase_d    = phase_q;
        case (state_q)
            IDLE, DONE: if (start) begin
                state_d = FETCH;
                addr_d  = '0;
                len_d   = SLOW;
            end
            FETCH: state_d = LOAD;
            LOAD: begin
                state_d    = PLAY;
                period_d   = rom_q;
                note_cnt_d = '0;
                half_cnt_d = '0;
                phase_d    = 1'b0;
            end
            PLAY: begin
                note_cnt_d = note_cnt_q + 27'd1;
                half_cnt_d = (half_cnt_q == period_q) ? '0 : half_cnt_q + 1'b1;
                phase_d    = (half_cnt_q == period_q) ? ~phase_q : phase_q;
                if (note_end) begin
                    // Tempo switch is independent of the wrap/finish decision below.
                    if (addr_q == SWITCH) len_d = FAST;
                    if (addr_q < LAST) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = FETCH;
                    end else if (loop_en) begin
                        addr_d  = '0;
                        len_d   = SLOW;
                        state_d = FETCH;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop) begin
            state_d = IDLE;
            addr_d  = '0;
        end
    end
    assign sample          = (state_q != PLAY || period_q == '0) ? '0 : (phase_q ? AMP : -AMP);
    assign left_sample     = sample;
    assign right_sample    = sample;
    assign write_audio_out = (state_q == PLAY) && audio_out_allowed;
    assign rom_addr        = addr_q;
    assign busy            = (state_q == FETCH) || (state_q == LOAD) || (state_q == PLAY);
    assign done            = (state_q == DONE);
endmodule

// File: tb/tb_note_sequencer.sv
// tb_note_sequencer: directed checks of note_sequencer with a 4-entry note ROM.
module tb_note_sequencer;
    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic               start = 1'b0, stop = 1'b0, loop_en = 1'b0, allowed = 1'b1;
    logic [9:0]         rom_addr;
    logic [19:0]        rom_q = '0;
    logic               wr, busy, done;
    logic signed [31:0] ls, rs;
    int                 chk_cnt = 0, pass_cnt = 0;
    int                 bp_lo = -1, bp_hi = -1;
    logic [19:0]        rom [4] = '{20'd2, 20'd0, 20'd4, 20'd1};

    note_sequencer #(
        .ADDR_W(10), .PERIOD_W(20), .LAST_ADDR(3), .TEMPO_SWITCH(1),
        .TEMPO_SLOW(20), .TEMPO_FAST(10), .AMPLITUDE(1000)
    ) dut (
        .CLOCK_50(clk), .resetn(resetn), .start(start), .stop(stop), .loop_en(loop_en),
        .rom_addr(rom_addr), .rom_q(rom_q), .audio_out_allowed(allowed),
        .write_audio_out(wr), .left_sample(ls), .right_sample(rs), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rom_q <= rom[rom_addr[1:0]];

    task automatic check(input string tag, input int got, input int exp);
        chk_cnt++;
        if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        else pass_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered just after the edge into FETCH; leaves just after the edge ending PLAY.
    task automatic expect_note(input int addr, input int dur, input int per);
        int exp_s;
        check("fetch_busy", busy, 1);
        check("fetch_addr", rom_addr, addr);
        check("fetch_wr", wr, 0);
        step();
        check("load_busy", busy, 1);
        check("load_addr", rom_addr, addr);
        check("load_wr", wr, 0);
        check("load_smp", ls, 0);
        step();
        for (int i = 0; i < dur; i++) begin
            allowed = !(i >= bp_lo && i <= bp_hi);
            #1;
            exp_s = (per == 0) ? 0 : (((i / (per + 1)) % 2) ? 1000 : -1000);
            check($sformatf("play_wr a%0d c%0d", addr, i), wr, int'(allowed));
            check($sformatf("play_l a%0d c%0d", addr, i), ls, exp_s);
            check($sformatf("play_r a%0d c%0d", addr, i), rs, exp_s);
            check($sformatf("play_addr a%0d c%0d", addr, i), rom_addr, addr);
            check("play_done", done, 0);
            step();
        end
        allowed = 1'b1;
    endtask

    initial begin
        repeat (2) step();
        check("rst_wr", wr, 0);
        check("rst_l", ls, 0);
        check("rst_r", rs, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_addr", rom_addr, 0);
        resetn = 1'b1;
        repeat (2) step();
        check("idle_busy", busy, 0);

        // Basic sequence, no loop
        start = 1'b1;
        step();
        start = 1'b0;
        expect_note(0, 20, 2);
        expect_note(1, 20, 0);
        expect_note(2, 10, 4);
        expect_note(3, 10, 1);
        check("end_done", done, 1);
        check("end_busy", busy, 0);
        check("end_wr", wr, 0);
        check("end_addr", rom_addr, 3);
        step();
        check("hold_done", done, 1);

        // Restart from DONE with loop; start held high through the first note
        // and backpressure in the middle of it
        loop_en = 1'b1;
        start = 1'b1;
        step();
        bp_lo = 5;
        bp_hi = 9;
        expect_note(0, 20, 2);
        bp_lo = -1;
        bp_hi = -1;
        start = 1'b0;
        expect_note(1, 20, 0);
        expect_note(2, 10, 4);
        expect_note(3, 10, 1);
        expect_note(0, 20, 2);

        // stop beats start during PLAY
        check("pre_stop_addr", rom_addr, 1);
        repeat (5) step();
        check("pre_stop_wr", wr, 1);
        stop = 1'b1;
        start = 1'b1;
        step();
        stop = 1'b0;
        check("stop_busy", busy, 0);
        check("stop_addr", rom_addr, 0);
        check("stop_wr", wr, 0);
        check("stop_smp", ls, 0);
        check("stop_done", done, 0);
        step();
        start = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_addr", rom_addr, 0);

        // Asynchronous reset mid-note
        repeat (6) step();
        check("pre_rst_wr", wr, 1);
        #2 resetn = 1'b0;
        #1;
        check("arst_wr", wr, 0);
        check("arst_l", ls, 0);
        check("arst_r", rs, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_addr", rom_addr, 0);
        step();
        resetn = 1'b1;
        repeat (3) step();
        check("post_rst_busy", busy, 0);
        check("post_rst_wr", wr, 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("post_rst_start", busy, 1);
        check("post_rst_addr", rom_addr, 0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
